pattern_checker: RTL and testbench

- Downstream sink for the FHD gray-ramp pattern generator. Consumes h_sync, v_sync, d_en and data[7:0].
- Checks line timing: active pixels per line and active lines per frame.
- Checks the pixel data ramp rule and reports per-line/per-frame errors, a saturating error count and a lock indication.
- Used on-board with the generator in loopback; results are shown on LEDs/ILA.

---
 rtl/pattern_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_pattern_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_checker.sv
// pattern_checker: line/frame timing and gray-ramp data checker for the FHD pattern generator.
// Optional macro CHK_DATA_EN enables the per-pixel ramp and run-length data rule.
module pattern_checker #(
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int RUN_MAX     = 7,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        clear,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        d_en,
  input  logic [7:0]  data,
  output logic        line_done,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] err_cnt,
  output logic [10:0] line_cnt,
  output logic        locked
);

  typedef enum logic [1:0] {WAIT_VS, WAIT_DE, ACTIVE, BLANK} state_t;

  state_t      state_q, state_d;
  logic        v_sync_q, d_en_q, clear_q, vs_prev_q, de_prev_q;
  logic [10:0] pix_cnt_q, pix_cnt_d, line_idx_q, line_idx_d, line_cnt_q, line_cnt_d;
  logic        line_bad_q, line_bad_d, frame_bad_q, frame_bad_d, need_vs_q, need_vs_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        line_done_q, line_done_d, frame_done_q, frame_done_d;
  logic        line_err_q, line_err_d, frame_err_q, frame_err_d, locked_q, locked_d;
  logic        vs_rise, de_rise, start_line, pix_step, pix_bad;
  logic        line_fail, frame_end, frame_fail;
  logic        unused_inputs;

  assign vs_rise    = v_sync_q & ~vs_prev_q;
  assign de_rise    = d_en_q & ~de_prev_q;
  assign start_line = ((state_q == WAIT_DE) || (state_q == BLANK)) && de_rise && !vs_rise;
  assign pix_step   = (state_q == ACTIVE) && d_en_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      v_sync_q  <= 1'b0;
      d_en_q    <= 1'b0;
      clear_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      v_sync_q  <= v_sync;
      d_en_q    <= d_en;
      clear_q   <= clear;
      vs_prev_q <= v_sync_q;
      de_prev_q <= d_en_q;
    end
  end

`ifdef CHK_DATA_EN
  logic [7:0] data_q, prev_q, prev_d, run_q, run_d;

  // Run length saturates so a long zero stretch cannot wrap into a false error.
  always_comb begin
    prev_d  = prev_q;
    run_d   = run_q;
    pix_bad = 1'b0;
    if (start_line) begin
      prev_d = data_q;
      run_d  = 8'd1;
    end else if (pix_step) begin
      prev_d = data_q;
      if (data_q == prev_q) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      else                  run_d = 8'd1;
      if ((data_q != prev_q) && (data_q != prev_q + 8'd1) && (data_q != 8'd0)) pix_bad = 1'b1;
      if ((data_q != 8'd0) && (run_d > 8'(RUN_MAX))) pix_bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      data_q <= 8'd0;
      prev_q <= 8'd0;
      run_q  <= 8'd0;
    end else begin
      data_q <= data;
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

  assign unused_inputs = h_sync;
`else
  assign pix_bad       = 1'b0;
  assign unused_inputs = ^{h_sync, data, 8'(RUN_MAX)};
`endif

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_idx_d   = line_idx_q;
    line_cnt_d   = line_cnt_q;
    line_bad_d   = line_bad_q;
    frame_bad_d  = frame_bad_q;
    need_vs_d    = need_vs_q;
    err_cnt_d    = err_cnt_q;
    good_cnt_d   = good_cnt_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    line_fail    = 1'b0;
    frame_end    = 1'b0;
    frame_fail   = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_rise) state_d = WAIT_DE;
      WAIT_DE: if (de_rise) begin
        state_d    = ACTIVE;
        pix_cnt_d  = 11'd1;
        line_bad_d = 1'b0;
      end
      ACTIVE: begin
        if (d_en_q) begin
          if (pix_cnt_q != 11'h7FF) pix_cnt_d = pix_cnt_q + 11'd1;
          if (pix_bad) line_bad_d = 1'b1;
        end else begin
          line_fail   = line_bad_q | (pix_cnt_q != 11'(H_ACTIVE));
          line_done_d = 1'b1;
          line_err_d  = line_fail;
          if (line_fail && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
          line_cnt_d  = line_idx_q;
          frame_bad_d = frame_bad_q | line_fail;
          state_d     = BLANK;
          if (line_idx_q == 11'(V_ACTIVE - 1)) begin
            frame_end   = 1'b1;
            frame_fail  = frame_bad_q | line_fail;
            line_idx_d  = 11'd0;
            frame_bad_d = 1'b0;
            need_vs_d   = 1'b1;
          end else begin
            line_idx_d = line_idx_q + 11'd1;
          end
        end
      end
      BLANK: begin
        if (vs_rise) begin
          // A v_sync before the frame's last line closes the frame as failed.
          state_d     = WAIT_DE;
          need_vs_d   = 1'b0;
          line_idx_d  = 11'd0;
          frame_bad_d = 1'b0;
          if (line_idx_q != 11'd0) begin
            frame_end  = 1'b1;
            frame_fail = 1'b1;
          end
        end else if (de_rise) begin
          state_d    = ACTIVE;
          pix_cnt_d  = 11'd1;
          line_bad_d = need_vs_q && (line_idx_q == 11'd0);
          need_vs_d  = 1'b0;
        end
      end
      default: state_d = WAIT_VS;
    endcase
    if (frame_end) begin
      frame_done_d = 1'b1;
      frame_err_d  = frame_fail;
      if (frame_fail)                             good_cnt_d = 8'd0;
      else if (good_cnt_q != 8'(LOCK_FRAMES))     good_cnt_d = good_cnt_q + 8'd1;
    end
    if (clear_q) begin
      err_cnt_d  = 16'd0;
      good_cnt_d = 8'd0;
    end
    locked_d = (good_cnt_d == 8'(LOCK_FRAMES));
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= WAIT_VS;
      pix_cnt_q    <= 11'd0;
      line_idx_q   <= 11'd0;
      line_cnt_q   <= 11'd0;
      line_bad_q   <= 1'b0;
      frame_bad_q  <= 1'b0;
      need_vs_q    <= 1'b0;
      err_cnt_q    <= 16'd0;
      good_cnt_q   <= 8'd0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      line_idx_q   <= line_idx_d;
      line_cnt_q   <= line_cnt_d;
      line_bad_q   <= line_bad_d;
      frame_bad_q  <= frame_bad_d;
      need_vs_q    <= need_vs_d;
      err_cnt_q    <= err_cnt_d;
      good_cnt_q   <= good_cnt_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      locked_q     <= locked_d;
    end
  end

  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign line_cnt   = line_cnt_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: directed line/frame vectors with a scoreboard for pattern_checker.
// Data-fault lines expect an error only when CHK_DATA_EN is defined.
`timescale 1ns/1ps
module tb_pattern_checker;

  localparam int H = 16;
  localparam int V = 4;
  localparam int RUN = 3;
  localparam int LOCKF = 2;
`ifdef CHK_DATA_EN
  localparam bit DATA_CHK = 1'b1;
`else
  localparam bit DATA_CHK = 1'b0;
`endif

  typedef enum int {NORMAL, SHORT, LONG, JUMP, PLATEAU} kind_t;
  typedef struct packed {
    logic        ld, fd, le, fe;
    logic [15:0] ec;
    logic [10:0] lc;
    logic        lk;
  } evt_t;

  logic        clock = 1'b0, n_reset = 1'b0, clear = 1'b0;
  logic        h_sync = 1'b0, v_sync = 1'b0, d_en = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        line_done, frame_done, line_err, frame_err, locked;
  logic [15:0] err_cnt;
  logic [10:0] line_cnt;

  evt_t exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   m_line_idx = 0, m_line_cnt = 0, m_err_cnt = 0, m_good = 0;
  bit   m_frame_bad = 0, m_need_vs = 0, m_armed = 0;

  pattern_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .RUN_MAX(RUN), .LOCK_FRAMES(LOCKF)) dut (
    .clock(clock), .n_reset(n_reset), .clear(clear), .h_sync(h_sync), .v_sync(v_sync),
    .d_en(d_en), .data(data), .line_done(line_done), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err), .err_cnt(err_cnt), .line_cnt(line_cnt),
    .locked(locked)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  initial begin
    evt_t act, e;
    forever begin
      @(negedge clock);
      if (line_done || frame_done) begin
        act = '{line_done, frame_done, line_err, frame_err, err_cnt, line_cnt, locked};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_event: got ld=%0b fd=%0b le=%0b fe=%0b ec=%0d lc=%0d lk=%0b, required none",
                   act.ld, act.fd, act.le, act.fe, act.ec, act.lc, act.lk);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            miscompares++;
            $display("[TB] FAIL event: got ld=%0b fd=%0b le=%0b fe=%0b ec=%0d lc=%0d lk=%0b, required ld=%0b fd=%0b le=%0b fe=%0b ec=%0d lc=%0d lk=%0b",
                     act.ld, act.fd, act.le, act.fe, act.ec, act.lc, act.lk,
                     e.ld, e.fd, e.le, e.fe, e.ec, e.lc, e.lk);
          end
        end
      end
    end
  end

  function automatic logic [7:0] ramp(input int i);
    if (i < 4) return 8'd0;
    return 8'(1 + (i - 4) / RUN);
  endfunction

  // Sends one line and pushes the hand-derived response for it.
  task automatic applyStimulus(input kind_t kind, input bit do_clear);
    int         n;
    logic [7:0] v;
    bit         le;
    evt_t       e;
    n = (kind == SHORT) ? H - 1 : (kind == LONG) ? H + 1 : H;
    for (int i = 0; i < n; i++) begin
      v = ramp(i);
      if (kind == JUMP && i == 10) v = ramp(9) + 8'd2;
      if (kind == PLATEAU && i >= 4 && i <= 4 + RUN) v = 8'd1;
      @(posedge clock); #1;
      d_en = 1'b1;
      data = v;
    end
    @(posedge clock); #1;
    d_en  = 1'b0;
    data  = 8'd0;
    clear = do_clear;
    if (m_armed) begin
      le = (kind == SHORT) || (kind == LONG) || (DATA_CHK && (kind == JUMP || kind == PLATEAU)) ||
           (m_need_vs && m_line_idx == 0);
      m_need_vs = 1'b0;
      if (le && m_err_cnt < 65535) m_err_cnt++;
      m_frame_bad = m_frame_bad | le;
      e = '0;
      e.ld = 1'b1;
      e.le = le;
      e.lc = 11'(m_line_idx);
      m_line_cnt = m_line_idx;
      if (m_line_idx == V - 1) begin
        e.fd = 1'b1;
        e.fe = m_frame_bad;
        if (m_frame_bad) m_good = 0;
        else if (m_good < LOCKF) m_good++;
        m_line_idx  = 0;
        m_frame_bad = 1'b0;
        m_need_vs   = 1'b1;
      end else begin
        m_line_idx++;
      end
      if (do_clear) begin
        m_err_cnt = 0;
        m_good    = 0;
      end
      e.ec = 16'(m_err_cnt);
      e.lk = (m_good == LOCKF);
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    clear  = 1'b0;
    h_sync = 1'b1;
    @(posedge clock); #1;
    h_sync = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic sendVsync();
    evt_t e;
    @(posedge clock); #1;
    v_sync = 1'b1;
    if (m_armed && m_line_idx != 0) begin
      e = '0;
      e.fd = 1'b1;
      e.fe = 1'b1;
      e.ec = 16'(m_err_cnt);
      e.lc = 11'(m_line_cnt);
      m_good = 0;
      exp_q.push_back(e);
    end
    m_armed     = 1'b1;
    m_line_idx  = 0;
    m_frame_bad = 1'b0;
    m_need_vs   = 1'b0;
    repeat (3) @(posedge clock); #1;
    v_sync = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic sendFrame(input int bad_line, input kind_t kind, input bit with_vs);
    for (int l = 0; l < V; l++) applyStimulus((l == bad_line) ? kind : NORMAL, 1'b0);
    if (with_vs) sendVsync();
  endtask

  task automatic checkReset();
    @(negedge clock);
    checkOutput("rst_line_done", 32'(line_done), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_line_err", 32'(line_err), 0);
    checkOutput("rst_frame_err", 32'(frame_err), 0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 0);
    checkOutput("rst_line_cnt", 32'(line_cnt), 0);
    checkOutput("rst_locked", 32'(locked), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    checkReset();
    @(posedge clock); #1;
    n_reset = 1'b1;

    applyStimulus(NORMAL, 1'b0);
    sendVsync();
    sendFrame(-1, NORMAL, 1'b1);
    @(negedge clock); checkOutput("locked_after_f1", 32'(locked), 0);
    sendFrame(-1, NORMAL, 1'b1);
    @(negedge clock); checkOutput("locked_after_f2", 32'(locked), 1);
    sendFrame(-1, NORMAL, 1'b1);

    sendFrame(1, SHORT, 1'b1);
    @(negedge clock); checkOutput("err_cnt_short", 32'(err_cnt), 1);
    checkOutput("locked_drop", 32'(locked), 0);
    sendFrame(-1, NORMAL, 1'b1);
    sendFrame(-1, NORMAL, 1'b1);
    @(negedge clock); checkOutput("locked_regain", 32'(locked), 1);

    sendFrame(2, LONG, 1'b1);
    sendFrame(0, JUMP, 1'b1);
    sendFrame(3, PLATEAU, 1'b1);
    @(negedge clock); checkOutput("err_cnt_data", 32'(err_cnt), DATA_CHK ? 4 : 2);

    applyStimulus(NORMAL, 1'b0);
    applyStimulus(NORMAL, 1'b0);
    sendVsync();
    sendFrame(-1, NORMAL, 1'b1);

    sendFrame(-1, NORMAL, 1'b0);
    applyStimulus(NORMAL, 1'b0);
    sendVsync();
    @(negedge clock); checkOutput("err_cnt_extra", 32'(err_cnt), DATA_CHK ? 5 : 3);

    applyStimulus(SHORT, 1'b1);
    @(negedge clock); checkOutput("err_cnt_clear", 32'(err_cnt), 0);
    for (int l = 1; l < V; l++) applyStimulus(NORMAL, 1'b0);
    sendVsync();
    sendFrame(-1, NORMAL, 1'b1);
    sendFrame(-1, NORMAL, 1'b1);
    @(negedge clock); checkOutput("locked_pre_rst", 32'(locked), 1);

    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      d_en = 1'b1;
      data = ramp(i);
    end
    n_reset = 1'b0;
    m_line_idx = 0; m_line_cnt = 0; m_err_cnt = 0; m_good = 0;
    m_frame_bad = 1'b0; m_need_vs = 1'b0; m_armed = 1'b0;
    checkReset();
    @(posedge clock); #1;
    n_reset = 1'b1;
    applyStimulus(NORMAL, 1'b0);
    sendVsync();
    sendFrame(-1, NORMAL, 1'b1);

    repeat (10) @(posedge clock);
    checkOutput("pending_events", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
